// File: rtl/vx_tcu_tfr_align.sv
// Two-stage exponent alignment for the tensor-core fused dot product:
// stage 1 derives per-lane shift amounts and kill flags, stage 2 performs
// the arithmetic right shift with sticky collection and holds the result.

package VX_tcu_pkg;

    typedef struct packed {
        logic nan;
        logic inf;
        logic overflow;
        logic underflow;
    } fedp_excep_t;

endpackage

module vx_tcu_tfr_align
    import VX_tcu_pkg::*;
#(
    parameter int unsigned TCK   = 4,
    parameter int unsigned EXP_W = 10,
    parameter int unsigned WA    = 28
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [31:0]               req_id,
    input  logic [EXP_W-1:0]          max_exp,
    input  logic [TCK:0][EXP_W-1:0]   exponents,
    input  logic [TCK:0][24:0]        raw_sigs,
    input  fedp_excep_t               exceptions,
    input  logic [TCK-1:0]            lane_mask,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [31:0]               req_id_out,
    output logic [TCK:0][WA-1:0]      aligned_sigs,
    output logic [TCK:0]              sticky,
    output logic [EXP_W-1:0]          max_exp_out,
    output fedp_excep_t               exceptions_out
);

    localparam int unsigned SIG_W   = 25;
    localparam int unsigned GUARD_W = WA - SIG_W;
    localparam int unsigned SH_W    = $clog2(WA);

    // Handshake
    logic s1_ld;
    logic s2_ld;

    // Stage 1 state
    logic                    v1_q, v1_d;
    logic [31:0]             s1_id_q, s1_id_d;
    logic [EXP_W-1:0]        s1_me_q, s1_me_d;
    fedp_excep_t             s1_exc_q, s1_exc_d;
    logic [TCK:0][SIG_W-1:0] s1_sig_q, s1_sig_d;
    logic [TCK:0][SH_W-1:0]  s1_sh_q, s1_sh_d;
    logic [TCK:0]            s1_big_q, s1_big_d;
    logic [TCK:0]            s1_kill_q, s1_kill_d;

    // Stage 2 state (drives the outputs)
    logic                    v2_q, v2_d;
    logic [31:0]             s2_id_q, s2_id_d;
    logic [EXP_W-1:0]        s2_me_q, s2_me_d;
    fedp_excep_t             s2_exc_q, s2_exc_d;
    logic [TCK:0][WA-1:0]    s2_al_q, s2_al_d;
    logic [TCK:0]            s2_st_q, s2_st_d;

    // Stage 1 helpers
    logic                    exc_any;
    logic [TCK:0]            lane_en;
    logic [TCK:0][EXP_W-1:0] sh_raw;

    // Stage 2 helpers
    logic [TCK:0][WA-1:0]    ext;
    logic [TCK:0][WA-1:0]    shr;
    logic [TCK:0][WA-1:0]    lowmask;

    assign exc_any = |exceptions;
    assign lane_en = {1'b1, lane_mask};

    // Pipeline handshake with bubble collapse
    assign s2_ld    = v1_q && (!v2_q || ready_out);
    assign ready_in = !v1_q || s2_ld;
    assign s1_ld    = valid_in && ready_in;

    // Stage valid bits
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (s1_ld) begin
            v1_d = 1'b1;
        end else if (s2_ld) begin
            v1_d = 1'b0;
        end
        if (s2_ld) begin
            v2_d = 1'b1;
        end else if (v2_q && ready_out) begin
            v2_d = 1'b0;
        end
    end

    // Per-lane shift distance; lanes above the global max are not shifted
    always_comb begin
        for (int i = 0; i <= int'(TCK); i++) begin
            sh_raw[i] = max_exp - exponents[i];
            if (exponents[i] > max_exp) begin
                sh_raw[i] = '0;
            end
        end
    end

    // Stage 1 next state: shift amounts, overflow-of-width and kill flags
    always_comb begin
        s1_id_d   = s1_id_q;
        s1_me_d   = s1_me_q;
        s1_exc_d  = s1_exc_q;
        s1_sig_d  = s1_sig_q;
        s1_sh_d   = s1_sh_q;
        s1_big_d  = s1_big_q;
        s1_kill_d = s1_kill_q;
        if (s1_ld) begin
            s1_id_d  = req_id;
            s1_me_d  = max_exp;
            s1_exc_d = exceptions;
            s1_sig_d = raw_sigs;
            for (int i = 0; i <= int'(TCK); i++) begin
                s1_big_d[i]  = (32'(sh_raw[i]) >= WA);
                s1_sh_d[i]   = s1_big_d[i] ? '0 : SH_W'(sh_raw[i]);
                s1_kill_d[i] = exc_any || !lane_en[i];
            end
        end
    end

    // Guarded significand, arithmetic shift and mask of discarded bits
    always_comb begin
        for (int i = 0; i <= int'(TCK); i++) begin
            ext[i]     = {s1_sig_q[i], {GUARD_W{1'b0}}};
            shr[i]     = $signed(ext[i]) >>> s1_sh_q[i];
            lowmask[i] = ~({WA{1'b1}} << s1_sh_q[i]);
        end
    end

    // Stage 2 next state: aligned significands and sticky bits
    always_comb begin
        s2_id_d  = s2_id_q;
        s2_me_d  = s2_me_q;
        s2_exc_d = s2_exc_q;
        s2_al_d  = s2_al_q;
        s2_st_d  = s2_st_q;
        if (s2_ld) begin
            s2_id_d  = s1_id_q;
            s2_me_d  = s1_me_q;
            s2_exc_d = s1_exc_q;
            for (int i = 0; i <= int'(TCK); i++) begin
                if (s1_kill_q[i]) begin
                    s2_al_d[i] = '0;
                    s2_st_d[i] = 1'b0;
                end else if (s1_big_q[i]) begin
                    s2_al_d[i] = '0;
                    s2_st_d[i] = |s1_sig_q[i];
                end else begin
                    s2_al_d[i] = shr[i];
                    s2_st_d[i] = |(ext[i] & lowmask[i]);
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1_q      <= 1'b0;
            s1_id_q   <= '0;
            s1_me_q   <= '0;
            s1_exc_q  <= '0;
            s1_sig_q  <= '0;
            s1_sh_q   <= '0;
            s1_big_q  <= '0;
            s1_kill_q <= '0;
            v2_q      <= 1'b0;
            s2_id_q   <= '0;
            s2_me_q   <= '0;
            s2_exc_q  <= '0;
            s2_al_q   <= '0;
            s2_st_q   <= '0;
        end else begin
            v1_q      <= v1_d;
            s1_id_q   <= s1_id_d;
            s1_me_q   <= s1_me_d;
            s1_exc_q  <= s1_exc_d;
            s1_sig_q  <= s1_sig_d;
            s1_sh_q   <= s1_sh_d;
            s1_big_q  <= s1_big_d;
            s1_kill_q <= s1_kill_d;
            v2_q      <= v2_d;
            s2_id_q   <= s2_id_d;
            s2_me_q   <= s2_me_d;
            s2_exc_q  <= s2_exc_d;
            s2_al_q   <= s2_al_d;
            s2_st_q   <= s2_st_d;
        end
    end

    assign valid_out      = v2_q;
    assign req_id_out     = s2_id_q;
    assign max_exp_out    = s2_me_q;
    assign exceptions_out = s2_exc_q;
    assign aligned_sigs   = s2_al_q;
    assign sticky         = s2_st_q;

endmodule
